regfile_writeback_ctrl: RTL

//  Producer-side writer for the register file's write port (waddr/wdata/wen).
//  - Accepts results from two sources, ALU (a_*) and load unit (m_*), over valid/ready.
//  - Buffers them in an in-order FIFO and retires one write per cycle.
//  - Provides a forwarding lookup so the read stage sees values still queued.

---
 rtl/regfile_writeback_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfile_writeback_ctrl.sv
// Register file write-port producer: arbitrates ALU/load results into an
// in-order FIFO, retires one write per cycle and forwards queued values.
module regfile_writeback_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [ADDR_WIDTH-1:0]   a_addr,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic                    m_valid,
   output logic                    m_ready,
   input  logic [ADDR_WIDTH-1:0]   m_addr,
   input  logic [DATA_WIDTH-1:0]   m_data,
   input  logic                    stall,
   output logic                    wen,
   output logic [ADDR_WIDTH-1:0]   waddr,
   output logic [DATA_WIDTH-1:0]   wdata,
   input  logic [ADDR_WIDTH-1:0]   fwd_addr,
   output logic                    fwd_hit,
   output logic [DATA_WIDTH-1:0]   fwd_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic                  full;
   logic                  m_acc;
   logic                  a_acc;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;
   logic [PW-1:0]         idx;

   // Ready does not look at a same-cycle pop; the load unit wins ties.
   assign full    = (count == FULL_CNT);
   assign m_ready = !rst && !full;
   assign a_ready = !rst && !full && !m_valid;

   assign m_acc   = m_valid && m_ready;
   assign a_acc   = a_valid && a_ready;
   assign in_addr = m_acc ? m_addr : a_addr;
   assign in_data = m_acc ? m_data : a_data;

   // Writes to x0 are consumed but never queued.
   assign push    = (m_acc || a_acc) && (in_addr != '0);

   assign wen     = (count != '0) && !stall && !rst;
   assign pop     = wen;
   assign waddr   = addr_q[rd_ptr];
   assign wdata   = data_q[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   // FIFO storage; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= in_addr;
         data_q[wr_ptr] <= in_data;
      end
   end

   // Scan oldest to youngest so the youngest match is kept last.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (!rst && (fwd_addr != '0) && ((PW+1)'(i) < count) &&
             (addr_q[idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[idx];
         end
      end
   end

endmodule
